note_lane_scroller: RTL and testbench

- Game-play core. Consumes the one-cycle tempo tick from the clock divider and scrolls a LANES x ROWS note grid one row toward the strike row per tick.
- Pulls new chart rows from the upstream note source over a valid/ready handshake.
- Judges player button presses against the strike row and maintains score and combo.
- Feeds the display renderer (grid) and the score/sound logic (pulses).

---
 rtl/note_lane_scroller.sv | 169 ++++++++++++++++
 tb/tb_note_lane_scroller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_scroller.sv
// Rhythm-game core: scrolls a LANES x ROWS note grid toward the strike row on each tempo
// tick, pulls chart rows over valid/ready, and judges button presses into score and combo.
module note_lane_scroller #(
  parameter int LANES   = 4,
  parameter int ROWS    = 8,
  parameter int SCORE_W = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  tick,
  input  logic                  start,
  input  logic                  note_valid,
  input  logic [LANES-1:0]      note_row,
  input  logic                  note_last,
  output logic                  note_ready,
  input  logic [LANES-1:0]      btn,
  output logic [LANES*ROWS-1:0] grid,
  output logic [SCORE_W-1:0]    score,
  output logic [7:0]            combo,
  output logic                  hit_pulse,
  output logic                  miss_pulse,
  output logic                  playing,
  output logic                  done
);

  localparam int CNT_W = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam int H_W   = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state, state_nxt;
  logic [LANES-1:0]       btn_q;
  logic [CNT_W-1:0]       drain_cnt, drain_nxt;
  logic [LANES*ROWS-1:0]  grid_nxt;
  logic [SCORE_W-1:0]     score_nxt;
  logic [7:0]             combo_nxt;
  logic                   hit_nxt, miss_nxt;

  logic                   active;
  logic                   scroll;
  logic                   transfer;
  logic [LANES-1:0]       row0;
  logic [LANES-1:0]       edges;
  logic [LANES-1:0]       hits;
  logic [LANES-1:0]       bad;
  logic [LANES-1:0]       row0_left;
  logic [LANES-1:0]       entry;
  logic                   miss_any;
  logic [H_W-1:0]         h_cnt;
  logic                   bonus;
  logic [SCORE_W:0]       prod;
  logic [SCORE_W:0]       ssum;
  logic [8:0]             csum;

  assign active     = (state == PLAY) || (state == DRAIN);
  assign note_ready = tick && (state == PLAY);
  assign transfer   = note_ready && note_valid;
  assign scroll     = active && tick;
  assign row0       = grid[LANES-1:0];
  assign edges      = btn & ~btn_q;
  assign hits       = active ? (edges & row0) : '0;
  assign bad        = active ? (edges & ~row0) : '0;
  // Hits are cleared before the shift so a same-cycle press never also counts as a miss.
  assign row0_left  = row0 & ~hits;
  assign entry      = transfer ? note_row : '0;
  assign miss_any   = (|bad) || (scroll && (|row0_left));

  always_comb begin
    h_cnt = '0;
    for (int l = 0; l < LANES; l++) begin
      h_cnt = h_cnt + H_W'(hits[l]);
    end
  end

  assign bonus = (combo >= 8'd8);
  assign prod  = (SCORE_W+1)'(h_cnt) * (SCORE_W+1)'(bonus ? 2 : 1);
  assign ssum  = {1'b0, score} + prod;
  assign csum  = {1'b0, combo} + 9'(h_cnt);

  assign playing = active;
  assign done    = (state == DONE);

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    grid_nxt  = grid;
    score_nxt = score;
    combo_nxt = combo;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;

    if (active) begin
      if (scroll) begin
        grid_nxt = {entry, grid[LANES*ROWS-1:LANES]};
      end else begin
        grid_nxt[LANES-1:0] = row0_left;
      end

      score_nxt = ssum[SCORE_W] ? '1 : ssum[SCORE_W-1:0];

      if (miss_any) begin
        combo_nxt = 8'd0;
      end else if (csum[8]) begin
        combo_nxt = 8'hff;
      end else begin
        combo_nxt = csum[7:0];
      end

      hit_nxt  = (h_cnt != '0);
      miss_nxt = miss_any;
    end

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = PLAY;
          grid_nxt  = '0;
          score_nxt = '0;
          combo_nxt = 8'd0;
          hit_nxt   = 1'b0;
          miss_nxt  = 1'b0;
        end
      end
      PLAY: begin
        if (transfer && note_last) begin
          state_nxt = DRAIN;
          drain_nxt = '0;
        end
      end
      DRAIN: begin
        if (tick) begin
          drain_nxt = drain_cnt + CNT_W'(1);
          if (drain_cnt == CNT_W'(ROWS - 2)) begin
            state_nxt = DONE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      btn_q      <= '0;
      drain_cnt  <= '0;
      grid       <= '0;
      score      <= '0;
      combo      <= 8'd0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      btn_q      <= btn;
      drain_cnt  <= drain_nxt;
      grid       <= grid_nxt;
      score      <= score_nxt;
      combo      <= combo_nxt;
      hit_pulse  <= hit_nxt;
      miss_pulse <= miss_nxt;
    end
  end

endmodule

// File: tb/tb_note_lane_scroller.sv
// Directed testbench for note_lane_scroller: scroll/drain timing, hit judging, combo bonus,
// bad presses, underrun, score saturation and asynchronous reset.
module tb_note_lane_scroller;

  logic        clk = 1'b0;
  logic        n_rst, tick, start, note_valid, note_last;
  logic [3:0]  note_row, btn;
  logic        note_ready;
  logic [31:0] grid;
  logic [15:0] score;
  logic [7:0]  combo;
  logic        hit_pulse, miss_pulse, playing, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  note_lane_scroller #(.LANES(4), .ROWS(8), .SCORE_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .tick(tick), .start(start),
    .note_valid(note_valid), .note_row(note_row), .note_last(note_last),
    .note_ready(note_ready), .btn(btn), .grid(grid), .score(score), .combo(combo),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .playing(playing), .done(done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    n_rst = 1'b0;
    #1;
    n_rst = 1'b1;
    cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic tick_row(input logic v, input logic [3:0] r, input logic l);
    tick = 1'b1; note_valid = v; note_row = r; note_last = l;
    cyc();
    tick = 1'b0; note_valid = 1'b0; note_row = 4'h0; note_last = 1'b0;
  endtask

  task automatic press(input logic [3:0] m);
    btn = m;
    cyc();
    btn = 4'h0;
    cyc();
  endtask

  // Feeds `notes` lane-0 notes, then hits `hits` of them between ticks (no combo bonus yet).
  task automatic run_lane0(input int notes, input int hits);
    for (int k = 1; k <= 7 + hits; k++) begin
      tick_row(k <= notes, (k <= notes) ? 4'b0001 : 4'b0000, 1'b0);
      if (k >= 8) press(4'b0001);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; tick = 1'b0; start = 1'b0; note_valid = 1'b0;
    note_row = 4'h0; note_last = 1'b0; btn = 4'h0;
    #2;
    checks++; if (grid !== 32'h0) begin errors++; $display("FAIL reset_grid: got %h expected 0", grid); end
    checks++; if (score !== 16'h0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if ({combo, hit_pulse, miss_pulse, playing, done} !== 12'h0) begin errors++; $display("FAIL reset_flags: got %h expected 0", {combo, hit_pulse, miss_pulse, playing, done}); end
    cyc();
    n_rst = 1'b1;
    cyc();
    tick = 1'b1; note_valid = 1'b1; note_row = 4'hf;
    #1;
    checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL idle_ready: got %b expected 0", note_ready); end
    cyc();
    tick = 1'b0; note_valid = 1'b0; note_row = 4'h0;
    checks++; if ({grid, playing} !== 33'h0) begin errors++; $display("FAIL idle_tick_ignored: got %h expected 0", {grid, playing}); end
  endtask

  task automatic test_scroll_drain();
    logic [31:0] exp_grid [0:6];
    exp_grid[0] = 32'h0201_0000; exp_grid[1] = 32'h0020_1000; exp_grid[2] = 32'h0002_0100;
    exp_grid[3] = 32'h0000_2010; exp_grid[4] = 32'h0000_0201; exp_grid[5] = 32'h0000_0020;
    exp_grid[6] = 32'h0000_0002;
    restart();
    checks++; if ({playing, done} !== 2'b10) begin errors++; $display("FAIL start_play: got %b expected 10", {playing, done}); end
    tick = 1'b1; note_valid = 1'b1; note_row = 4'b0001;
    #1;
    checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL play_ready: got %b expected 1", note_ready); end
    cyc();
    tick = 1'b0; note_valid = 1'b0;
    checks++; if (grid !== 32'h1000_0000) begin errors++; $display("FAIL scroll_t1: got %h expected 10000000", grid); end
    tick_row(1'b1, 4'b0000, 1'b0);
    checks++; if (grid !== 32'h0100_0000) begin errors++; $display("FAIL scroll_t2: got %h expected 01000000", grid); end
    tick_row(1'b1, 4'b0010, 1'b1);
    checks++; if (grid !== 32'h2010_0000) begin errors++; $display("FAIL scroll_t3: got %h expected 20100000", grid); end
    checks++; if ({playing, done} !== 2'b10) begin errors++; $display("FAIL drain_entered: got %b expected 10", {playing, done}); end
    for (int i = 0; i < 7; i++) begin
      tick = 1'b1; note_valid = 1'b1; note_row = 4'hf;
      #1;
      checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL drain_ready %0d: got %b expected 0", i, note_ready); end
      cyc();
      tick = 1'b0; note_valid = 1'b0; note_row = 4'h0;
      checks++; if (grid !== exp_grid[i]) begin errors++; $display("FAIL drain_grid %0d: got %h expected %h", i, grid, exp_grid[i]); end
      checks++; if (miss_pulse !== (i == 5)) begin errors++; $display("FAIL drain_miss %0d: got %b expected %b", i, miss_pulse, i == 5); end
      checks++; if (done !== (i == 6)) begin errors++; $display("FAIL drain_done %0d: got %b expected %b", i, done, i == 6); end
    end
    checks++; if (combo !== 8'd0) begin errors++; $display("FAIL drain_combo: got %0d expected 0", combo); end
    tick_row(1'b1, 4'hf, 1'b0);
    checks++; if ({grid, done, playing} !== {32'h2, 2'b10}) begin errors++; $display("FAIL done_hold: got %h expected %h", {grid, done, playing}, {32'h2, 2'b10}); end
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if ({grid, score, playing, done} !== {32'h0, 16'h0, 2'b10}) begin errors++; $display("FAIL restart_from_done: got %h expected %h", {grid, score, playing, done}, {32'h0, 16'h0, 2'b10}); end
    tick_row(1'b1, 4'b0100, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (grid !== 32'h4000_0000) begin errors++; $display("FAIL start_ignored_play: got %h expected 40000000", grid); end
  endtask

  task automatic test_hit();
    restart();
    tick_row(1'b1, 4'b0100, 1'b0);
    for (int i = 0; i < 7; i++) tick_row(1'b0, 4'b0000, 1'b0);
    checks++; if (grid !== 32'h0000_0004) begin errors++; $display("FAIL hit_setup: got %h expected 00000004", grid); end
    btn = 4'b0100;
    cyc();
    checks++; if ({hit_pulse, miss_pulse, score, combo, grid} !== {2'b10, 16'd1, 8'd1, 32'h0}) begin errors++; $display("FAIL hit_lane2: got %h expected %h", {hit_pulse, miss_pulse, score, combo, grid}, {2'b10, 16'd1, 8'd1, 32'h0}); end
    cyc();
    checks++; if ({hit_pulse, miss_pulse, score, combo} !== {2'b00, 16'd1, 8'd1}) begin errors++; $display("FAIL hit_hold: got %h expected %h", {hit_pulse, miss_pulse, score, combo}, {2'b00, 16'd1, 8'd1}); end
    btn = 4'h0;
    cyc();
  endtask

  task automatic test_combo_bonus();
    restart();
    for (int k = 1; k <= 16; k++) begin
      tick_row(k <= 9, (k <= 8) ? 4'b0001 : ((k == 9) ? 4'b1001 : 4'b0000), 1'b0);
      if (k >= 8 && k <= 15) press(4'b0001);
    end
    checks++; if ({score, combo} !== {16'd8, 8'd8}) begin errors++; $display("FAIL combo_setup: got %h expected %h", {score, combo}, {16'd8, 8'd8}); end
    tick = 1'b1; btn = 4'b1001;
    cyc();
    tick = 1'b0; btn = 4'h0;
    checks++; if ({score, combo} !== {16'd12, 8'd10}) begin errors++; $display("FAIL combo_bonus: got %h expected %h", {score, combo}, {16'd12, 8'd10}); end
    checks++; if ({hit_pulse, miss_pulse, grid} !== {2'b10, 32'h0}) begin errors++; $display("FAIL combo_no_miss: got %h expected %h", {hit_pulse, miss_pulse, grid}, {2'b10, 32'h0}); end
  endtask

  task automatic test_bad_press();
    restart();
    run_lane0(6, 5);
    checks++; if ({score, combo} !== {16'd5, 8'd5}) begin errors++; $display("FAIL bad_setup: got %h expected %h", {score, combo}, {16'd5, 8'd5}); end
    tick_row(1'b0, 4'b0000, 1'b0);
    btn = 4'b0011;
    cyc();
    btn = 4'h0;
    checks++; if ({score, combo, hit_pulse, miss_pulse} !== {16'd6, 8'd0, 2'b11}) begin errors++; $display("FAIL bad_press: got %h expected %h", {score, combo, hit_pulse, miss_pulse}, {16'd6, 8'd0, 2'b11}); end
  endtask

  task automatic test_underrun();
    restart();
    tick_row(1'b1, 4'b1000, 1'b0);
    #1;
    checks++; if (note_ready !== 1'b0) begin errors++; $display("FAIL ready_no_tick: got %b expected 0", note_ready); end
    tick = 1'b1; note_valid = 1'b0; note_row = 4'hf;
    #1;
    checks++; if (note_ready !== 1'b1) begin errors++; $display("FAIL underrun_ready: got %b expected 1", note_ready); end
    cyc();
    tick = 1'b0; note_row = 4'h0;
    checks++; if ({grid, playing, miss_pulse} !== {32'h0800_0000, 2'b10}) begin errors++; $display("FAIL underrun_grid: got %h expected %h", {grid, playing, miss_pulse}, {32'h0800_0000, 2'b10}); end
  endtask

  task automatic test_saturation();
    restart();
    for (int k = 0; k < 8; k++) tick_row(1'b1, 4'hf, 1'b0);
    for (int n = 1; n <= 8194; n++) begin
      tick = 1'b1; note_valid = 1'b1; note_row = 4'hf; btn = 4'hf;
      cyc();
      tick = 1'b0; note_valid = 1'b0; btn = 4'h0;
      if (n == 8192) begin
        checks++; if (score !== 16'd65528) begin errors++; $display("FAIL sat_pre: got %0d expected 65528", score); end
      end
      if (n >= 8193) begin
        checks++; if (score !== 16'd65535) begin errors++; $display("FAIL sat_%0d: got %0d expected 65535", n, score); end
      end
      cyc();
    end
    checks++; if ({combo, miss_pulse} !== {8'd255, 1'b0}) begin errors++; $display("FAIL sat_combo: got %h expected %h", {combo, miss_pulse}, {8'd255, 1'b0}); end
  endtask

  task automatic test_reset_mid_play();
    restart();
    run_lane0(7, 5);
    checks++; if ({score, grid} !== {16'd5, 32'h0000_0110}) begin errors++; $display("FAIL rst_setup: got %h expected %h", {score, grid}, {16'd5, 32'h0000_0110}); end
    tick = 1'b1; note_valid = 1'b1; note_row = 4'hf; btn = 4'h1;
    #2;
    n_rst = 1'b0;
    #1;
    checks++; if ({grid, score, combo, hit_pulse, miss_pulse, playing, done, note_ready} !== 61'h0) begin errors++; $display("FAIL rst_mid_play: got %h expected 0", {grid, score, combo, hit_pulse, miss_pulse, playing, done, note_ready}); end
    #3;
    n_rst = 1'b1;
    cyc();
    tick = 1'b0; note_valid = 1'b0; btn = 4'h0;
    checks++; if ({grid, score, playing} !== 49'h0) begin errors++; $display("FAIL rst_stays_idle: got %h expected 0", {grid, score, playing}); end
  endtask

  initial begin
    test_reset();
    test_scroll_drain();
    test_hit();
    test_combo_bonus();
    test_bad_press();
    test_underrun();
    test_saturation();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
